mem_ctrl_sram: RTL
==================

Name: mem_ctrl_sram

Overview:
- Data-memory controller directly downstream of cpu_core's memory port.
- Consumes mem_addr/mem_wdata/mem_ctrl_signal and returns mem_rdata/mem_stall.
- Runs a multi-cycle FSM against an asynchronous 32-bit SRAM: byte-lane enables, load extension, misalignment detection.
- Holds the pipeline with mem_stall until the access completes.

Parameters:
- ADDR_WIDTH, 32, CPU address width.
- SRAM_AW, 20, SRAM word-address width.
- WAIT_CYCLES, 1, extra SRAM access cycles beyond the first (≥0).

Ports:
- clk_50M  in  1  system clock.
- reset_btn  in  1  synchronous, active-high reset.
- mem_addr  in  ADDR_WIDTH  byte address from the CPU.
- mem_wdata  in  32  store data; value is in the low bits for SB/SH.
- mem_ctrl_signal  in  5  [0] read, [1] write, [3:2] size (00 byte, 01 half, 10 word, 11 illegal), [4] sign-extend.
- mem_rdata  out  32  extended load result.
- mem_stall  out  1  pipeline hold.
- addr_err  out  1  one-cycle pulse on a rejected request.
- sram_addr  out  SRAM_AW  word address = mem_addr[SRAM_AW+1:2].
- sram_data_o  out  32  write data.
- sram_data_i  in  32  read data.
- sram_data_oe  out  1  drive enable for the data bus tristate, which lives at top level.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low strobes.
- sram_be_n  out  4  active-low byte enables, little-endian lanes.

Behaviour:
- Reset values:
  - mem_stall=0, mem_rdata=0, addr_err=0.
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_be_n=4'hF.
  - sram_addr=0, sram_data_o=0, sram_data_oe=0.
  - FSM=IDLE, counter=0.
- Reset is sampled every cycle. Asserting it in any state forces the reset values on the next edge, which aborts an in-flight access; a write is abandoned with we_n deasserted.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request (read=write=0): mem_stall=0, strobes inactive.
- IDLE, legal request: mem_stall=1 combinationally. Register address, lane enables and write data; load counter=WAIT_CYCLES; go to ACCESS.
- IDLE, illegal request: the request is illegal if any of these hold:
  - read and write both set;
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0.
  - Response: mem_stall=0, no strobe activity, addr_err=1 next cycle, mem_rdata=0; stay in IDLE.
- ACCESS:
  - ce_n=0 and be_n active.
  - Read: oe_n=0, we_n=1; the full word is read, with be_n=0000.
  - Write: we_n=0, oe_n=1, data_oe=1.
  - mem_stall=1.
  - counter≠0: decrement and stay.
  - counter=0: a read captures sram_data_i through the load aligner into mem_rdata; go to DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- DONE:
  - mem_stall=0 so the CPU advances; ce_n=oe_n=we_n=1.
  - For a write, data_oe stays 1 this cycle as hold time; it is 0 afterwards.
  - mem_rdata remains valid and is held until the next completed read.
  - Next state is IDLE unconditionally. The held request is never re-issued because the pipeline advances during DONE.
- Latency: mem_stall is high for WAIT_CYCLES+2 cycles (IDLE cycle plus ACCESS); the result is valid in the DONE cycle.
- Store lanes:
  - byte: data_o={4{wdata[7:0]}}, be_n=~(4'b0001<<addr[1:0]).
  - half: data_o={2{wdata[15:0]}}, be_n = 4'b1100 if addr[1]=0, else 4'b0011.
  - word: data_o=wdata, be_n=0000.
- Loads:
  - Select the byte at addr[1:0] or the half at addr[1].
  - Sign-extend when bit4=1, zero-extend otherwise.
  - Word ignores bit4.
- Inputs must be held stable while mem_stall=1. Changes to them during ACCESS are ignored, because the registered copy is used.

Decomposition:
- common_defs.svh gains:
  - MEMCTL_RD/WR/SIZE/SEXT bit positions;
  - MEM_SIZE_BYTE/HALF/WORD codes;
  - a memctl_state_t enum.
- One combinational sub-module, mem_load_align, takes the raw word, offset, size and sext and returns the 32-bit result; it is reused by a future cache path.
- Lane/enable generation stays inline.

Test Plan (WAIT_CYCLES=1, SRAM behavioural model):
- LW: addr 0x10, SRAM word 4 = 0x12345678 → sram_addr=0x4; mem_stall high 3 cycles; mem_rdata=0x12345678 in the 4th cycle; oe_n low exactly 2 cycles.
- LB/LBU: addr 0x13, word = 0x80FF0000 → LB gives 0xFFFFFF80; LBU gives 0x00000080; LH at 0x12 gives 0xFFFF80FF.
- SB: addr 0x6, wdata 0x000000AB → be_n=4'b1011, data_o=0xABABABAB, we_n low 2 cycles; SRAM word 1 changes only in byte 2.
- Misaligned LH at 0x1 and SW at 0x2 → addr_err one-cycle pulse each; ce_n stays 1; mem_stall stays 0; mem_rdata=0.
- reset_btn high during the first ACCESS cycle of an SW → next cycle all strobes inactive, stall=0, data_oe=0, SRAM unchanged; a following LW completes normally.
- Back-to-back SW 0xDEADBEEF to 0x20 then LW 0x20 → DONE→IDLE separation observed; mem_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/mem_ctrl_sram_pkg.sv
// mem_ctrl_sram_pkg
//   Shared definitions for the SRAM data-memory controller:
//   - bit positions inside the CPU's 5-bit mem_ctrl_signal
//   - access-size codes
//   - controller FSM state type
//   - a request-alignment helper used by the front end
package mem_ctrl_sram_pkg;

    // mem_ctrl_signal bit positions
    localparam int MEMCTL_RD      = 0;
    localparam int MEMCTL_WR      = 1;
    localparam int MEMCTL_SIZE_LO = 2;
    localparam int MEMCTL_SIZE_HI = 3;
    localparam int MEMCTL_SEXT    = 4;

    // access-size codes carried in mem_ctrl_signal[3:2]
    localparam logic [1:0] MEM_SIZE_BYTE    = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF    = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD    = 2'b10;
    localparam logic [1:0] MEM_SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } memctl_state_t;

    // True when the byte offset cannot hold an access of the given size.
    function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == MEM_SIZE_HALF) && off[0]) ||
               ((size == MEM_SIZE_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
//   Combinational load aligner: picks the byte/half/word addressed by
//   offset out of a raw 32-bit memory word and zero- or sign-extends it.
//   Ports:
//     raw    in  32  word as read from memory
//     offset in  2   byte offset of the access within the word
//     size   in  2   MEM_SIZE_* code
//     sext   in  1   sign-extend byte/half results (ignored for word)
//     result out 32  extended load value
module mem_load_align
    import mem_ctrl_sram_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (offset)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = offset[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        result = raw;
        case (size)
            MEM_SIZE_BYTE: result = {{24{sext & byte_sel[7]}}, byte_sel};
            MEM_SIZE_HALF: result = {{16{sext & half_sel[15]}}, half_sel};
            default:       result = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl_sram.sv
// mem_ctrl_sram
//   Data-memory controller between the CPU memory port and an asynchronous
//   32-bit SRAM. A legal request is registered in IDLE, driven to the SRAM
//   for WAIT_CYCLES+1 cycles in ACCESS, and released in DONE, where the CPU
//   sees mem_stall drop and the load result on mem_rdata.
//   Ports:
//     clk_50M, reset_btn          clock, synchronous active-high reset
//     mem_addr/mem_wdata          CPU byte address and store data
//     mem_ctrl_signal             {sext, size[1:0], write, read}
//     mem_rdata                   extended load result (held until next read)
//     mem_stall                   pipeline hold
//     addr_err                    one-cycle pulse after a rejected request
//     sram_addr/sram_data_o/i     SRAM word address and data
//     sram_data_oe                data-bus drive enable (tristate at top level)
//     sram_ce_n/oe_n/we_n/be_n    active-low SRAM strobes and byte lanes
module mem_ctrl_sram
    import mem_ctrl_sram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk_50M,
    input  logic                  reset_btn,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [4:0]            mem_ctrl_signal,
    output logic [31:0]           mem_rdata,
    output logic                  mem_stall,
    output logic                  addr_err,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [31:0]           sram_data_o,
    input  logic [31:0]           sram_data_i,
    output logic                  sram_data_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    memctl_state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               req_wr;
    logic [1:0]         req_off;
    logic [1:0]         req_size;
    logic               req_sext;
    logic [3:0]         req_be_n;

    // ---------------- request decode ----------------
    logic       rd, wr, sext;
    logic [1:0] size, off;
    logic       req_any, req_bad, req_ok;

    assign rd      = mem_ctrl_signal[MEMCTL_RD];
    assign wr      = mem_ctrl_signal[MEMCTL_WR];
    assign size    = mem_ctrl_signal[MEMCTL_SIZE_HI:MEMCTL_SIZE_LO];
    assign sext    = mem_ctrl_signal[MEMCTL_SEXT];
    assign off     = mem_addr[1:0];
    assign req_any = rd | wr;
    assign req_bad = req_any & ((rd & wr) | (size == MEM_SIZE_ILLEGAL) | req_misaligned(size, off));
    assign req_ok  = req_any & ~req_bad;

    // High address bits beyond the SRAM's reach are ignored.
    generate
        if (ADDR_WIDTH > SRAM_AW + 2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_addr[ADDR_WIDTH-1:SRAM_AW+2];
        end
    endgenerate

    // ---------------- store lane steering ----------------
    // Reads always fetch the full word; only stores narrow the lanes.
    logic [3:0]  lane_be_n;
    logic [31:0] lane_data;

    always_comb begin
        lane_be_n = 4'b0000;
        lane_data = mem_wdata;
        if (wr) begin
            case (size)
                MEM_SIZE_BYTE: begin
                    lane_be_n = ~(4'b0001 << off);
                    lane_data = {4{mem_wdata[7:0]}};
                end
                MEM_SIZE_HALF: begin
                    lane_be_n = off[1] ? 4'b0011 : 4'b1100;
                    lane_data = {2{mem_wdata[15:0]}};
                end
                default: begin
                    lane_be_n = 4'b0000;
                    lane_data = mem_wdata;
                end
            endcase
        end
    end

    // ---------------- load aligner ----------------
    logic [31:0] load_val;

    mem_load_align u_align (
        .raw    (sram_data_i),
        .offset (req_off),
        .size   (req_size),
        .sext   (req_sext),
        .result (load_val)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk_50M) begin
        if (reset_btn) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Strobes decode straight from state so that a reset, which forces
    // IDLE, releases we_n on the very next cycle and abandons the write.
    always_comb begin
        state_nxt    = state;
        mem_stall    = 1'b0;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_be_n    = 4'hF;
        sram_data_oe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_ok) begin
                    mem_stall = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_stall    = 1'b1;
                sram_ce_n    = 1'b0;
                sram_be_n    = req_be_n;
                sram_oe_n    = req_wr;
                sram_we_n    = ~req_wr;
                sram_data_oe = req_wr;
                if (cnt == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // keep driving write data one cycle past we_n for hold time
                sram_data_oe = req_wr;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            req_wr   <= 1'b0;
            req_off  <= 2'b00;
            req_size <= MEM_SIZE_BYTE;
            req_sext <= 1'b0;
            req_be_n <= 4'hF;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        cnt      <= CNT_LOAD;
                        addr_q   <= mem_addr[SRAM_AW+1:2];
                        wdata_q  <= lane_data;
                        req_wr   <= wr;
                        req_off  <= off;
                        req_size <= size;
                        req_sext <= sext;
                        req_be_n <= lane_be_n;
                    end else if (req_bad) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0)   cnt     <= cnt - 1'b1;
                    else if (!req_wr) rdata_q <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign sram_addr   = addr_q;
    assign sram_data_o = wdata_q;
    assign mem_rdata   = rdata_q;
    assign addr_err    = err_q;

endmodule
